// File: rtl/program_io_pkg.sv
// program_io_pkg: state encoding and stream format constants shared by the
// UART program loader and program dumper.
package program_io_pkg;
    localparam int WORD_BYTES = 4;
    localparam int BYTE_IDX_W = $clog2(WORD_BYTES);
    typedef enum logic [2:0] {IDLE, SEND_SIZE, FETCH, SEND_WORD, COMPLETED} state_t;
endpackage

// File: rtl/program_dumper_word_serializer.sv
// word_serializer: loads a 32-bit word and emits its bytes LSB-first over a
// valid/ready handshake, pulsing done on the transfer of the last byte.
module word_serializer
    import program_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        ready,
    output logic        valid,
    output logic [7:0]  data,
    output logic        done
);
    localparam logic [BYTE_IDX_W-1:0] LAST = BYTE_IDX_W'(WORD_BYTES - 1);
    logic [31:0]           buffer;
    logic [BYTE_IDX_W-1:0] idx;
    assign data = buffer[{idx, 3'b000} +: 8];
    assign done = valid && ready && idx == LAST;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buffer <= '0;
            idx    <= '0;
            valid  <= 1'b0;
        end else if (load) begin
            buffer <= word;
            idx    <= '0;
            valid  <= 1'b1;
        end else if (valid && ready) begin
            idx   <= idx + 1'b1;
            valid <= idx != LAST;
        end
    end
endmodule

// File: rtl/program_dumper.sv
// program_dumper: on start, reads a memory region word by word and streams it
// to the UART transmitter as [size header] + little-endian words.
module program_dumper
    import program_io_pkg::*;
#(
    parameter bit SEND_HEADER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [31:0] dump_size,
    output logic        busy,
    output logic        completed,
    output logic        uart_in_valid,
    output logic [7:0]  uart_in_data,
    input  logic        uart_in_ready,
    output logic [31:0] mem_out_addr,
    output logic        mem_out_valid,
    input  logic [31:0] mem_out_data,
    input  logic        mem_out_ready
);
    state_t      state, state_next;
    logic [31:0] base, size;
    logic [32:0] offset, offset_next;
    logic        take, ser_load, ser_done;
    logic [31:0] ser_word;
    assign take          = (state == IDLE || state == COMPLETED) && start;
    assign offset_next   = offset + 33'd4;
    assign busy          = state != IDLE && state != COMPLETED;
    assign completed     = state == COMPLETED;
    assign mem_out_valid = state == FETCH;
    assign mem_out_addr  = base + offset[31:0];
    // The serializer carries both the size header and fetched words.
    assign ser_load = (take && SEND_HEADER) || (state == FETCH && mem_out_ready);
    assign ser_word = state == FETCH ? mem_out_data : dump_size;
    word_serializer u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (ser_load),
        .word  (ser_word),
        .ready (uart_in_ready),
        .valid (uart_in_valid),
        .data  (uart_in_data),
        .done  (ser_done)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            base   <= '0;
            size   <= '0;
            offset <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                base   <= base_addr;
                size   <= dump_size;
                offset <= '0;
            end else if (state == SEND_WORD && ser_done) begin
                offset <= offset_next;
            end
        end
    end
    // Offset is 33 bits so a 0xFFFFFFFF-byte dump still terminates.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, COMPLETED:
                if (start) state_next = SEND_HEADER ? SEND_SIZE : (dump_size == '0 ? COMPLETED : FETCH);
            SEND_SIZE:
                if (ser_done) state_next = size == '0 ? COMPLETED : FETCH;
            FETCH:
                if (mem_out_ready) state_next = SEND_WORD;
            SEND_WORD:
                if (ser_done) state_next = offset_next < {1'b0, size} ? FETCH : COMPLETED;
            default:
                state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_program_dumper.sv
// tb_program_dumper: directed and randomised dumps checked against a
// byte-stream model built from the memory contents and region size.
module tb_program_dumper;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] dump_size = '0;
    logic        busy, completed, uart_in_valid, mem_out_valid;
    logic [7:0]  uart_in_data;
    logic [31:0] mem_out_addr;
    logic        uart_in_ready = 1'b0;
    logic [31:0] mem_out_data = '0;
    logic        mem_out_ready = 1'b0;
    logic        busy0, completed0, uart_valid0, mem_valid0;
    logic [7:0]  uart_data0;
    logic [31:0] mem_addr0;
    int checks = 0;
    int failures = 0;
    bit rnd = 1'b0;
    bit saw_mem_valid = 1'b0;
    bit saw_uart0 = 1'b0;
    logic [7:0]  got_bytes[$], exp_bytes[$];
    logic [31:0] got_addr[$], exp_addr[$];

    program_dumper #(.SEND_HEADER(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .dump_size(dump_size),
        .busy(busy), .completed(completed), .uart_in_valid(uart_in_valid), .uart_in_data(uart_in_data),
        .uart_in_ready(uart_in_ready), .mem_out_addr(mem_out_addr), .mem_out_valid(mem_out_valid),
        .mem_out_data(mem_out_data), .mem_out_ready(mem_out_ready)
    );

    program_dumper #(.SEND_HEADER(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .base_addr(base_addr), .dump_size(dump_size),
        .busy(busy0), .completed(completed0), .uart_in_valid(uart_valid0), .uart_in_data(uart_data0),
        .uart_in_ready(1'b1), .mem_out_addr(mem_addr0), .mem_out_valid(mem_valid0),
        .mem_out_data(32'h0), .mem_out_ready(1'b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h11223344;
        if (a == 32'h104) return 32'hAABBCCDD;
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Expected stream: size header, then ceil(size/4) whole words from base upward.
    function automatic void build(input logic [31:0] b, input logic [31:0] s);
        logic [63:0] nw;
        logic [31:0] a, d;
        exp_bytes.delete();
        exp_addr.delete();
        for (int k = 0; k < 4; k++) exp_bytes.push_back(s[8*k +: 8]);
        nw = ({32'b0, s} + 64'd3) / 64'd4;
        for (longint w = 0; w < longint'(nw); w++) begin
            a = b + 32'(w * 4);
            d = mem_word(a);
            exp_addr.push_back(a);
            for (int k = 0; k < 4; k++) exp_bytes.push_back(d[8*k +: 8]);
        end
    endfunction

    // Drives ready/memory responses after each falling edge, samples just before the rising edge.
    initial begin
        int lat = 0;
        int lat_target = 0;
        bit u_stall = 1'b0;
        bit m_stall = 1'b0;
        logic [7:0]  u_data = '0;
        logic [31:0] m_addr = '0;
        forever begin
            @(negedge clk);
            uart_in_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            mem_out_ready = 1'b0;
            if (mem_out_valid) begin
                if (lat >= lat_target) begin
                    mem_out_ready = 1'b1;
                    mem_out_data  = mem_word(mem_out_addr);
                    lat = 0;
                    lat_target = rnd ? int'($urandom_range(0, 5)) : 0;
                end else lat++;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                mem_out_ready = 1'b1;
                mem_out_data  = $urandom;
            end
            #4;
            if (uart_valid0) saw_uart0 = 1'b1;
            if (!reset) begin
                u_stall = 1'b0;
                m_stall = 1'b0;
                lat = 0;
            end else begin
                if (u_stall) check("uart_hold", {uart_in_valid, uart_in_data}, {1'b1, u_data});
                if (m_stall) check("mem_hold", {mem_out_valid, mem_out_addr}, {1'b1, m_addr});
                if (uart_in_valid && uart_in_ready) got_bytes.push_back(uart_in_data);
                if (mem_out_valid && mem_out_ready) got_addr.push_back(mem_out_addr);
                if (mem_out_valid) saw_mem_valid = 1'b1;
                u_stall = uart_in_valid && !uart_in_ready;
                u_data  = uart_in_data;
                m_stall = mem_out_valid && !mem_out_ready;
                m_addr  = mem_out_addr;
            end
        end
    end

    task automatic begin_dump(input logic [31:0] b, input logic [31:0] s);
        build(b, s);
        got_bytes.delete();
        got_addr.delete();
        saw_mem_valid = 1'b0;
        base_addr = b;
        dump_size = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        dump_size = $urandom;
    endtask

    task automatic run_dump(input logic [31:0] b, input logic [31:0] s, input bit poke, input string tag);
        int cyc = 0;
        begin_dump(b, s);
        while (!completed && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = poke && cyc == 12;
        end
        start = 1'b0;
        check({tag, "_timeout"}, 64'(cyc < 4000), 64'd1);
        check({tag, "_nbytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got_bytes[i]), 64'(exp_bytes[i]));
        check({tag, "_nreq"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
        check({tag, "_done"}, {completed, busy}, 2'b10);
    endtask

    initial begin
        int cyc;
        logic [7:0] b4;
        #12;
        check("reset_out", {busy, completed, uart_in_valid, mem_out_valid, uart_in_data, mem_out_addr}, '0);
        check("reset_out0", {busy0, completed0, uart_valid0, mem_valid0, uart_data0, mem_addr0}, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_dump(32'h100, 32'd8, 1'b0, "basic");
        b4 = got_bytes[4];
        check("basic_first_data", 64'(b4), 64'h44);
        run_dump(32'h200, 32'd0, 1'b0, "size0");
        check("size0_no_req", 64'(saw_mem_valid), 64'd0);
        dump_size = 32'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("nohdr_size0_done", {completed0, busy0, mem_valid0}, 3'b100);
        check("nohdr_no_bytes", 64'(saw_uart0), 64'd0);
        run_dump(32'h100, 32'd5, 1'b0, "size5");
        run_dump(32'h400, 32'd24, 1'b1, "poke");
        rnd = 1'b1;
        for (int i = 0; i < 6; i++)
            run_dump($urandom, $urandom_range(0, 40), 1'b0, $sformatf("rand%0d", i));
        rnd = 1'b0;
        run_dump(32'hFFFFFFFC, 32'd8, 1'b0, "wrap");
        begin_dump(32'h100, 32'd8);
        cyc = 0;
        while (got_bytes.size() < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("prereset_timeout", 64'(cyc < 200), 64'd1);
        check("prereset_byte", {uart_in_valid, uart_in_data}, {1'b1, 8'h22});
        #1 reset = 1'b0;
        #1;
        check("midreset_out", {busy, completed, uart_in_valid, mem_out_valid, uart_in_data, mem_out_addr}, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postreset_idle", {busy, completed}, 2'b00);
        run_dump(32'h100, 32'd8, 1'b0, "after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_dumper.md
Name: program_dumper

Overview:
- Transmit-side counterpart of the UART program loader.
- On a start pulse, reads a region of memory word by word through a request/response handshake and serialises it to the UART transmitter.
- Stream format matches what the loader consumes: 32-bit byte count, then the words, all little-endian (LSB byte first).
- Used for memory readback/dump to host and for loader round-trip tests.

Parameters:
SEND_HEADER, 1, 1: emit 4-byte size header before data; 0: data bytes only.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request to begin a dump; sampled only in IDLE or COMPLETED
base_addr  input  32  first word address; sampled with start
dump_size  input  32  region length in bytes; sampled with start
busy  output  1  high in any state other than IDLE/COMPLETED
completed  output  1  high in COMPLETED
uart_in_valid  output  1  byte on uart_in_data is valid for transmitter
uart_in_data  output  8  byte to transmit
uart_in_ready  input  1  transmitter accepts byte this cycle
mem_out_addr  output  32  word address of read request
mem_out_valid  output  1  read request pending
mem_out_data  input  32  read data; valid in cycle mem_out_ready=1
mem_out_ready  input  1  read completes this cycle

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - busy=0, completed=0, uart_in_valid=0, mem_out_valid=0.
  - uart_in_data=0, mem_out_addr=0.
  - Internal counters cleared.
  - Applies immediately mid-transfer; partial bytes/words are dropped, nothing resumes.
- States: IDLE, SEND_SIZE, FETCH, SEND_WORD, COMPLETED.
- IDLE/COMPLETED + start=1:
  - Latch base_addr, dump_size; clear byte index and offset.
  - Next state SEND_SIZE if SEND_HEADER=1, else FETCH (or COMPLETED directly if dump_size=0).
- Byte handshake (SEND_SIZE/SEND_WORD):
  - uart_in_valid=1 with byte k of the 32-bit buffer (k=0 first = bits 7:0).
  - Byte held stable until a cycle with uart_in_ready=1; that cycle is the transfer.
  - Next byte presented the following cycle, valid stays high.
  - Max throughput 1 byte/cycle.
  - After the transfer of byte 3, uart_in_valid drops in the next cycle unless another buffer is immediately loaded (it is not: FETCH always intervenes, giving one gap cycle).
- SEND_SIZE: buffer=latched dump_size. After byte 3: FETCH if dump_size>0, else COMPLETED.
- FETCH:
  - mem_out_valid=1, mem_out_addr = base + offset.
  - Held until mem_out_ready=1; in that cycle mem_out_data is captured into the buffer.
  - mem_out_valid=0 next cycle; go to SEND_WORD.
  - mem_out_ready while mem_out_valid=0 is ignored.
- SEND_WORD: after byte 3, offset += 4.
  - If offset < dump_size: FETCH.
  - Else: COMPLETED.
  - Word count = ceil(dump_size/4); a non-multiple-of-4 size still sends whole words.
- Arithmetic:
  - Address = base + offset mod 2^32; wraps silently past 0xFFFFFFFC.
  - Offset compare is unsigned 32-bit. Offset is 33 bits internally so sizes up to 0xFFFFFFFF terminate.
- Start outside IDLE/COMPLETED: ignored, latched values unchanged.
- COMPLETED: sticky until start (restarts) or reset.
- Request/valid outputs never toggle while awaiting their ready.

Decomposition:
- Package program_io_pkg:
  - state enum.
  - WORD_BYTES=4, byte-index width.
  - Shared with program_loader for format constants.
- Sub-module word_serializer: loads a 32-bit word, emits 4 bytes LSB-first over valid/ready, and pulses done on the byte-3 transfer. Used for both header and data.

Test Plan:
- Mem[0x100]=0x11223344, Mem[0x104]=0xAABBCCDD; start base=0x100, size=8, ready always 1, mem latency 1 -> bytes 08 00 00 00 44 33 22 11 DD CC BB AA; exactly 2 mem requests (0x100, 0x104); completed=1.
- size=0 -> bytes 00 00 00 00 only; no mem_out_valid ever; completed=1. With SEND_HEADER=0 -> no bytes; completed=1 the cycle after start.
- size=5 -> header 05 00 00 00 then 8 data bytes (2 words).
- Randomised uart_in_ready (~30%) and mem latency 0-5 cycles -> identical byte sequence; data and address stable during every stall.
- reset=0 asserted during the 3rd data byte -> all outputs 0 immediately. New start after release yields a full fresh stream from the header.
- start pulsed again mid-dump -> ignored. Start from COMPLETED with base=0xFFFFFFFC, size=8 -> requests 0xFFFFFFFC then 0x00000000.
